// File: rtl/redmule_tcdm_responder.sv
// redmule_tcdm_responder
// Multi-port TCDM slave that stands in for the cluster TCDM. It answers the
// MP narrow request ports of the RedMulE wrapper. Memory is MP word-interleaved
// banks with fixed-priority conflict arbitration and a 1-cycle response.
//
// Ports:
//   clk_i, rst_i      clock / synchronous active-high reset
//   tcdm_req_i        per-port request
//   tcdm_gnt_o        per-port grant (combinational, the only comb output)
//   tcdm_add_i        per-port byte address (bits [1:0] ignored)
//   tcdm_wen_i        per-port 1 = read, 0 = write
//   tcdm_be_i         per-port byte enables for writes
//   tcdm_data_i       per-port write data
//   tcdm_r_data_o     per-port read data (zero on write responses)
//   tcdm_r_valid_o    per-port response valid, one cycle after each grant
//   tcdm_r_opc_o      response opcode, always 0
//   tcdm_r_user_o     response user bit, always 0
//
// Optional feature: define REDMULE_TCDM_STALL_EN to add a random global stall
// driven by a 16-bit LFSR (about 25% of cycles). Without it, stall is 0.
module redmule_tcdm_responder #(
  parameter int MP         = 4,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int BANK_WORDS = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MP-1:0]      tcdm_req_i,
  output logic [MP-1:0]      tcdm_gnt_o,
  input  logic [MP*AW-1:0]   tcdm_add_i,
  input  logic [MP-1:0]      tcdm_wen_i,
  input  logic [MP*DW/8-1:0] tcdm_be_i,
  input  logic [MP*DW-1:0]   tcdm_data_i,
  output logic [MP*DW-1:0]   tcdm_r_data_o,
  output logic [MP-1:0]      tcdm_r_valid_o,
  output logic               tcdm_r_opc_o,
  output logic               tcdm_r_user_o
);

  localparam int BEW = DW / 8;
  localparam int NW  = MP * BANK_WORDS;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;

  // Word-interleaving makes the flat index {word, bank} simply the word
  // address modulo the total capacity; upper address bits wrap silently.
  function automatic logic [IW-1:0] flat_idx(input logic [AW-1:0] a);
    return IW'((a >> 2) & AW'(NW - 1));
  endfunction

  function automatic logic [AW-1:0] bank_of(input logic [AW-1:0] a);
    return (a >> 2) & AW'(MP - 1);
  endfunction

  logic [DW-1:0]    mem [NW];
  logic [MP-1:0]    won;
  logic             stall;
  logic [MP*DW-1:0] rdata_p1;
  logic [MP-1:0]    vld_p1;
  logic             opc_p1;
  logic             user_p1;

`ifdef REDMULE_TCDM_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  // One global stall so every port's grant drops together.
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Per bank, the lowest-index requester wins: a port loses if any
  // lower-index requester targets the same bank.
  always_comb begin
    won = '1;
    for (int i = 0; i < MP; i++) begin
      for (int j = 0; j < MP; j++) begin
        if (j < i && tcdm_req_i[j] &&
            bank_of(tcdm_add_i[j*AW +: AW]) == bank_of(tcdm_add_i[i*AW +: AW]))
          won[i] = 1'b0;
      end
    end
  end

  assign tcdm_gnt_o = tcdm_req_i & won & {MP{~stall}} & {MP{~rst_i}};

  // Stage p0 -> p1: memory update and response capture at the grant edge.
  // Granted ports always hit distinct banks, so the writes never collide.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (tcdm_gnt_o[i] && !tcdm_wen_i[i]) begin
        for (int b = 0; b < BEW; b++) begin
          if (tcdm_be_i[i*BEW + b])
            mem[flat_idx(tcdm_add_i[i*AW +: AW])][b*8 +: 8] <= tcdm_data_i[i*DW + b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= '0;
      rdata_p1 <= '0;
      opc_p1   <= 1'b0;
      user_p1  <= 1'b0;
    end else begin
      vld_p1  <= tcdm_gnt_o;
      opc_p1  <= 1'b0;
      user_p1 <= 1'b0;
      for (int i = 0; i < MP; i++) begin
        if (tcdm_gnt_o[i] && tcdm_wen_i[i])
          rdata_p1[i*DW +: DW] <= mem[flat_idx(tcdm_add_i[i*AW +: AW])];
        else
          rdata_p1[i*DW +: DW] <= '0;
      end
    end
  end

  assign tcdm_r_valid_o = vld_p1;
  assign tcdm_r_data_o  = rdata_p1;
  assign tcdm_r_opc_o   = opc_p1;
  assign tcdm_r_user_o  = user_p1;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
module tb_redmule_tcdm_responder;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [3:0]   wen;
  logic [127:0] r_data;
  logic [3:0]   r_valid;
  logic         r_opc;
  logic         r_user;

  logic [31:0]  a_arr  [4];
  logic [31:0]  d_arr  [4];
  logic [3:0]   be_arr [4];

  int n_vec = 0;
  int n_err = 0;
  int stall_cycles = 0;

  // Reference memory organised the way the behaviour is described:
  // bank = word address mod 4, row = (byte address / 16) mod 1024.
  logic [31:0] mm    [4][1024];
  bit          known [4][1024];

  redmule_tcdm_responder #(.MP(4), .DW(32), .AW(32), .BANK_WORDS(1024)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     ({a_arr[3], a_arr[2], a_arr[1], a_arr[0]}),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      ({be_arr[3], be_arr[2], be_arr[1], be_arr[0]}),
    .tcdm_data_i    ({d_arr[3], d_arr[2], d_arr[1], d_arr[0]}),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .tcdm_r_opc_o   (r_opc),
    .tcdm_r_user_o  (r_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bank_m(input logic [31:0] a);
    return int'((a / 4) % 4);
  endfunction

  function automatic int row_m(input logic [31:0] a);
    return int'((a / 16) % 1024);
  endfunction

  // Called with inputs already driven just after a rising edge. Checks the
  // grant, lets the edge happen, then checks the response.
  task automatic run_cycle(input string tag);
    logic [3:0]   eg;
    logic [3:0]   ev;
    logic [127:0] ed;
    logic [127:0] mask;
    #1;
    eg = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        eg[i] = 1'b1;
        for (int j = 0; j < i; j++)
          if (req[j] && bank_m(a_arr[j]) == bank_m(a_arr[i])) eg[i] = 1'b0;
      end
    end
`ifdef REDMULE_TCDM_STALL_EN
    if (gnt == 4'h0 && eg != 4'h0) begin
      eg = 4'h0;
      stall_cycles++;
    end
`endif
    chk({tag, " gnt"}, {124'd0, gnt}, {124'd0, eg});
    ev   = eg;
    ed   = '0;
    mask = '1;
    for (int i = 0; i < 4; i++) begin
      if (eg[i] && wen[i]) begin
        if (known[bank_m(a_arr[i])][row_m(a_arr[i])])
          ed[i*32 +: 32] = mm[bank_m(a_arr[i])][row_m(a_arr[i])];
        else
          mask[i*32 +: 32] = '0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (eg[i] && !wen[i]) begin
        for (int b = 0; b < 4; b++)
          if (be_arr[i][b]) mm[bank_m(a_arr[i])][row_m(a_arr[i])][b*8 +: 8] = d_arr[i][b*8 +: 8];
        if (be_arr[i] == 4'hF) known[bank_m(a_arr[i])][row_m(a_arr[i])] = 1'b1;
      end
    end
    #1;
    chk({tag, " r_valid"}, {124'd0, r_valid}, {124'd0, ev});
    chk({tag, " r_data"}, r_data & mask, ed & mask);
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] be);
    a_arr[p]  = a;
    wen[p]    = w;
    d_arr[p]  = d;
    be_arr[p] = be;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_port(i, 32'h0, 1'b1, 32'h0, 4'h0);
    rst = 1'b1;
    req = 4'hF;

    // Reset with all ports requesting: no grant, no response.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("reset gnt", {124'd0, gnt}, 128'd0);
      chk("reset r_valid", {124'd0, r_valid}, 128'd0);
    end
    chk("reset r_data", r_data, 128'd0);
    chk("reset opc/user", {126'd0, r_opc, r_user}, 128'd0);
    rst = 1'b0;
    req = 4'h0;
    @(posedge clk); #1;
    chk("post-reset r_valid", {124'd0, r_valid}, 128'd0);

    // Aligned burst write then read back on all ports.
    for (int i = 0; i < 4; i++) set_port(i, 32'h100 + 4*i, 1'b0, 32'h1111_0000 + i, 4'hF);
    req = 4'hF;
    run_cycle("burst wr");
    for (int i = 0; i < 4; i++) wen[i] = 1'b1;
    run_cycle("burst rd");
    for (int i = 0; i < 4; i++)
      chk("burst data", {96'd0, r_data[i*32 +: 32]}, {96'd0, 32'h1111_0000 + i});

    // Bank conflict: ports 0 and 2 read the same word.
    req = 4'b0001;
    set_port(0, 32'h200, 1'b0, 32'h5A5A_1234, 4'hF);
    run_cycle("conf pre");
    set_port(0, 32'h200, 1'b1, 32'h0, 4'h0);
    set_port(2, 32'h200, 1'b1, 32'h0, 4'h0);
    req = 4'b0101;
    run_cycle("conf c0");
    req = 4'b0100;
    run_cycle("conf c1");
    chk("conf data", {96'd0, r_data[64 +: 32]}, {96'd0, 32'h5A5A_1234});

    // Byte enables.
    req = 4'b0001;
    set_port(0, 32'h40, 1'b0, 32'hAABB_CCDD, 4'hF);
    run_cycle("be wr1");
    set_port(0, 32'h40, 1'b0, 32'h1122_3344, 4'b0101);
    run_cycle("be wr2");
    set_port(0, 32'h40, 1'b1, 32'h0, 4'h0);
    run_cycle("be rd");
    chk("be data", {96'd0, r_data[31:0]}, {96'd0, 32'hAA22_CC44});

    // Address wrap at 4 banks x 1024 words.
    set_port(0, 32'h0, 1'b0, 32'h0000_DEAD, 4'hF);
    run_cycle("wrap wr");
    set_port(0, 32'h4000, 1'b1, 32'h0, 4'h0);
    run_cycle("wrap rd");
    chk("wrap data", {96'd0, r_data[31:0]}, {96'd0, 32'h0000_DEAD});

    // Reset squashes a pending response; memory survives reset.
    set_port(1, 32'h104, 1'b1, 32'h0, 4'h0);
    req = 4'b0010;
    run_cycle("squash pre");
    req = 4'h0;
    @(posedge clk); #1;
    req = 4'b0010;
    #1;
`ifndef REDMULE_TCDM_STALL_EN
    chk("squash grant", {124'd0, gnt}, 128'd2);
`endif
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("squash gnt", {124'd0, gnt}, 128'd0);
    @(posedge clk); #1;
    chk("squash r_valid", {124'd0, r_valid}, 128'd0);
    rst = 1'b0;
    req = 4'h0;
    @(posedge clk); #1;
    chk("squash after", {124'd0, r_valid}, 128'd0);
    req = 4'b0010;
    run_cycle("retain rd");
    chk("retain data", {96'd0, r_data[63:32]}, {96'd0, 32'h1111_0001});

    // Random traffic over a small window so bank conflicts are frequent.
    for (int c = 0; c < 1000; c++) begin
      req = 4'($urandom);
      for (int i = 0; i < 4; i++)
        set_port(i, {22'd0, 10'($urandom)}, 1'($urandom), $urandom, 4'($urandom));
      run_cycle("rand");
    end
`ifdef REDMULE_TCDM_STALL_EN
    n_vec++;
    assert (stall_cycles > 100 && stall_cycles < 450) else begin
      n_err++;
      $error("FAIL stall ratio: observed %0d expected ~250 of 1000", stall_cycles);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
